// File: rtl/reg_ring_initiator_pkg.sv
// Shared definitions for the UDP register ring initiator: state encoding,
// error data pattern and watchdog width derivation.
`ifndef UDP_REG_ADDR_WIDTH
`define UDP_REG_ADDR_WIDTH 23
`endif
`ifndef CPCI_NF2_DATA_WIDTH
`define CPCI_NF2_DATA_WIDTH 32
`endif

package reg_ring_initiator_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Returned to the host whenever a transaction fails.
    localparam logic [31:0] ERR_DATA = 32'hdead_beef;

    // Counter width for a watchdog bounding a wait of 'cycles' cycles.
    function automatic int wd_width(input int cycles);
        return (cycles < 2) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/reg_ring_watchdog.sv
// Loadable saturating down-counter; expired is high while the count is zero.
module reg_ring_watchdog
    import reg_ring_initiator_pkg::*;
#(
    parameter int CNT_W = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             expired
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Load has priority; decrement stops at zero so the count never wraps.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == '0);

endmodule

// File: rtl/reg_ring_initiator.sv
// Originating end of the UDP register ring: launches one host transaction at
// a time, waits for it to come back from the ring tail and acknowledges it.
//
// state | meaning
// IDLE  | waiting for host_req; ring returns discarded
// ISSUE | drive the one-cycle ring request, arm the watchdog
// WAIT  | watch the tail for our source ID or watchdog expiry
// DONE  | host_ack pulse with read data / error
module reg_ring_initiator
    import reg_ring_initiator_pkg::*;
#(
    parameter int                           UDP_REG_SRC_WIDTH = 2,
    parameter logic [UDP_REG_SRC_WIDTH-1:0] SRC_ID            = '0,
    parameter int                           TIMEOUT_CYCLES    = 1024
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              host_req,
    input  logic                              host_rd_wr_L,
    input  logic [`UDP_REG_ADDR_WIDTH-1:0]    host_addr,
    input  logic [`CPCI_NF2_DATA_WIDTH-1:0]   host_wr_data,
    output logic                              host_ack,
    output logic [`CPCI_NF2_DATA_WIDTH-1:0]   host_rd_data,
    output logic                              host_error,
    output logic                              busy,
    output logic                              reg_req_out,
    output logic                              reg_ack_out,
    output logic                              reg_rd_wr_L_out,
    output logic [`UDP_REG_ADDR_WIDTH-1:0]    reg_addr_out,
    output logic [`CPCI_NF2_DATA_WIDTH-1:0]   reg_data_out,
    output logic [UDP_REG_SRC_WIDTH-1:0]      reg_src_out,
    input  logic                              reg_req_in,
    input  logic                              reg_ack_in,
    input  logic                              reg_rd_wr_L_in,
    input  logic [`UDP_REG_ADDR_WIDTH-1:0]    reg_addr_in,
    input  logic [`CPCI_NF2_DATA_WIDTH-1:0]   reg_data_in,
    input  logic [UDP_REG_SRC_WIDTH-1:0]      reg_src_in
);

    localparam int               CNT_W   = wd_width(TIMEOUT_CYCLES);
    // Loaded on ISSUE so expiry lands on the TIMEOUT_CYCLES-th WAIT cycle.
    localparam logic [CNT_W-1:0] WD_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [1:0]                           state_q, state_d;
    logic                                 rd_wr_q, rd_wr_d;
    logic [`UDP_REG_ADDR_WIDTH-1:0]       addr_q, addr_d;
    logic [`CPCI_NF2_DATA_WIDTH-1:0]      wdata_q, wdata_d;
    logic                                 req_out_q, req_out_d;
    logic                                 rd_wr_out_q, rd_wr_out_d;
    logic [`UDP_REG_ADDR_WIDTH-1:0]       addr_out_q, addr_out_d;
    logic [`CPCI_NF2_DATA_WIDTH-1:0]      data_out_q, data_out_d;
    logic [UDP_REG_SRC_WIDTH-1:0]         src_out_q, src_out_d;
    logic                                 ack_q, ack_d;
    logic [`CPCI_NF2_DATA_WIDTH-1:0]      rd_data_q, rd_data_d;
    logic                                 error_q, error_d;
    logic                                 busy_q, busy_d;
    logic                                 wd_load, wd_dec, wd_expired;
    logic                                 ours;

    // The return path's address and direction are not needed to match a return.
    logic unused_ret;
    assign unused_ret = ^{reg_rd_wr_L_in, reg_addr_in};

    assign ours = reg_req_in && (reg_src_in == SRC_ID);

    reg_ring_watchdog #(.CNT_W(CNT_W)) u_watchdog (
        .clk      (clk),
        .reset    (reset),
        .load     (wd_load),
        .load_val (WD_LOAD),
        .dec      (wd_dec),
        .expired  (wd_expired)
    );

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        rd_wr_d     = rd_wr_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        req_out_d   = 1'b0;
        rd_wr_out_d = rd_wr_out_q;
        addr_out_d  = addr_out_q;
        data_out_d  = data_out_q;
        src_out_d   = src_out_q;
        ack_d       = 1'b0;
        rd_data_d   = rd_data_q;
        error_d     = error_q;
        wd_load     = 1'b0;
        wd_dec      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (host_req) begin
                    rd_wr_d = host_rd_wr_L;
                    addr_d  = host_addr;
                    wdata_d = host_wr_data;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                req_out_d   = 1'b1;
                rd_wr_out_d = rd_wr_q;
                addr_out_d  = addr_q;
                data_out_d  = wdata_q;
                src_out_d   = SRC_ID;
                wd_load     = 1'b1;
                state_d     = ST_WAIT;
            end
            ST_WAIT: begin
                wd_dec = 1'b1;
                // A return in the expiry cycle still completes normally.
                if (ours) begin
                    ack_d     = 1'b1;
                    rd_data_d = reg_ack_in ? reg_data_in : ERR_DATA;
                    error_d   = !reg_ack_in;
                    state_d   = ST_DONE;
                end else if (wd_expired) begin
                    ack_d     = 1'b1;
                    rd_data_d = ERR_DATA;
                    error_d   = 1'b1;
                    state_d   = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State, capture and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            rd_wr_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            req_out_q   <= 1'b0;
            rd_wr_out_q <= 1'b0;
            addr_out_q  <= '0;
            data_out_q  <= '0;
            src_out_q   <= '0;
            ack_q       <= 1'b0;
            rd_data_q   <= '0;
            error_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_wr_q     <= rd_wr_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            req_out_q   <= req_out_d;
            rd_wr_out_q <= rd_wr_out_d;
            addr_out_q  <= addr_out_d;
            data_out_q  <= data_out_d;
            src_out_q   <= src_out_d;
            ack_q       <= ack_d;
            rd_data_q   <= rd_data_d;
            error_q     <= error_d;
            busy_q      <= busy_d;
        end
    end

    assign host_ack        = ack_q;
    assign host_rd_data    = rd_data_q;
    assign host_error      = error_q;
    assign busy            = busy_q;
    assign reg_req_out     = req_out_q;
    assign reg_ack_out     = 1'b0;
    assign reg_rd_wr_L_out = rd_wr_out_q;
    assign reg_addr_out    = addr_out_q;
    assign reg_data_out    = data_out_q;
    assign reg_src_out     = src_out_q;

endmodule

// File: tb/tb_reg_ring_initiator.sv
// Directed bench for reg_ring_initiator with a one-stage registered responder.
`ifndef UDP_REG_ADDR_WIDTH
`define UDP_REG_ADDR_WIDTH 23
`endif
`ifndef CPCI_NF2_DATA_WIDTH
`define CPCI_NF2_DATA_WIDTH 32
`endif

module tb_reg_ring_initiator;

    localparam int AW = `UDP_REG_ADDR_WIDTH;
    localparam int DW = `CPCI_NF2_DATA_WIDTH;
    localparam logic [31:0] DEAD = 32'hdead_beef;

    logic          clk = 1'b0;
    logic          reset;
    logic          host_req, host_rd_wr_L;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_wr_data;
    logic          host_ack, host_error, busy;
    logic [DW-1:0] host_rd_data;
    logic          reg_req_out, reg_ack_out, reg_rd_wr_L_out;
    logic [AW-1:0] reg_addr_out;
    logic [DW-1:0] reg_data_out;
    logic [1:0]    reg_src_out;
    logic          reg_req_in, reg_ack_in;
    logic [DW-1:0] reg_data_in;
    logic [1:0]    reg_src_in;

    // responder model and injection controls
    logic          resp_en, resp_ack;
    logic [DW-1:0] resp_data;
    logic          rsp_req, rsp_ack;
    logic [DW-1:0] rsp_data;
    logic [1:0]    rsp_src;
    logic          inj_req, inj_ack;
    logic [DW-1:0] inj_data;
    logic [1:0]    inj_src;

    int n_checks = 0;
    int n_errors = 0;

    // per-transaction observations
    int            req_at, ack_at, n_req, n_ack;
    logic          cap_rd;
    logic [AW-1:0] cap_addr;
    logic [DW-1:0] cap_data;
    logic [1:0]    cap_src;
    logic [DW-1:0] got_rd;
    logic          got_err;

    always #5 clk = ~clk;

    reg_ring_initiator #(
        .UDP_REG_SRC_WIDTH (2),
        .SRC_ID            (2'd0),
        .TIMEOUT_CYCLES    (16)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .host_req        (host_req),
        .host_rd_wr_L    (host_rd_wr_L),
        .host_addr       (host_addr),
        .host_wr_data    (host_wr_data),
        .host_ack        (host_ack),
        .host_rd_data    (host_rd_data),
        .host_error      (host_error),
        .busy            (busy),
        .reg_req_out     (reg_req_out),
        .reg_ack_out     (reg_ack_out),
        .reg_rd_wr_L_out (reg_rd_wr_L_out),
        .reg_addr_out    (reg_addr_out),
        .reg_data_out    (reg_data_out),
        .reg_src_out     (reg_src_out),
        .reg_req_in      (reg_req_in),
        .reg_ack_in      (reg_ack_in),
        .reg_rd_wr_L_in  (1'b0),
        .reg_addr_in     ('0),
        .reg_data_in     (reg_data_in),
        .reg_src_in      (reg_src_in)
    );

    // single registered responder
    always @(posedge clk) begin
        rsp_req  <= reg_req_out & resp_en;
        rsp_ack  <= resp_ack;
        rsp_data <= resp_data;
        rsp_src  <= reg_src_out;
    end

    assign reg_req_in  = rsp_req | inj_req;
    assign reg_ack_in  = inj_req ? inj_ack  : rsp_ack;
    assign reg_data_in = inj_req ? inj_data : rsp_data;
    assign reg_src_in  = inj_req ? inj_src  : rsp_src;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launch one host request, then run 'budget' cycles recording what happens.
    // Cycle n is the n-th cycle after host_req was sampled.
    task automatic do_txn(input logic rd, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                          input int budget, input int hreq1, input int hreq2, input int inj_at);
        req_at = -1; ack_at = -1; n_req = 0; n_ack = 0;
        host_rd_wr_L = rd; host_addr = addr; host_wr_data = wd;
        host_req = 1'b1;
        tick();
        host_req = 1'b0;
        for (int n = 1; n <= budget; n++) begin
            if (reg_req_out) begin
                n_req++; req_at = n;
                cap_rd = reg_rd_wr_L_out; cap_addr = reg_addr_out;
                cap_data = reg_data_out; cap_src = reg_src_out;
            end
            if (host_ack) begin
                n_ack++;
                if (ack_at < 0) ack_at = n;
                got_rd = host_rd_data; got_err = host_error;
            end
            host_req = (n == hreq1) || (n == hreq2);
            inj_req  = (n == inj_at);
            tick();
        end
        host_req = 1'b0;
        inj_req  = 1'b0;
    endtask

    initial begin
        int acks;
        reset = 1'b0;
        host_req = 1'b0; host_rd_wr_L = 1'b0; host_addr = '0; host_wr_data = '0;
        resp_en = 1'b1; resp_ack = 1'b1; resp_data = '0;
        inj_req = 1'b0; inj_ack = 1'b0; inj_data = '0; inj_src = 2'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack",   64'(host_ack), 64'd0);
        chk("rst_busy",  64'(busy), 64'd0);
        chk("rst_req",   64'(reg_req_out), 64'd0);
        chk("rst_rdata", 64'(host_rd_data), 64'd0);
        chk("rst_err",   64'(host_error), 64'd0);
        reset = 1'b1;
        tick();

        // read, registered responder acks with 5
        resp_en = 1'b1; resp_ack = 1'b1; resp_data = 32'h0000_0005;
        do_txn(1'b1, 23'h00_0010, 32'h0, 10, -1, -1, -1);
        chk("rd_req_at",  64'(req_at), 64'd2);
        chk("rd_n_req",   64'(n_req), 64'd1);
        chk("rd_ack_at",  64'(ack_at), 64'd4);
        chk("rd_n_ack",   64'(n_ack), 64'd1);
        chk("rd_data",    64'(got_rd), 64'h5);
        chk("rd_err",     64'(got_err), 64'd0);
        chk("rd_dir",     64'(cap_rd), 64'd1);
        chk("rd_busy_end", 64'(busy), 64'd0);

        // write; ring returns its own data which is passed through
        resp_data = 32'h0000_abcd;
        do_txn(1'b0, 23'h04_0001, 32'h0000_0001, 10, -1, -1, -1);
        chk("wr_addr",   64'(cap_addr), 64'h40001);
        chk("wr_data",   64'(cap_data), 64'h1);
        chk("wr_dir",    64'(cap_rd), 64'd0);
        chk("wr_src",    64'(cap_src), 64'd0);
        chk("wr_ack_at", 64'(ack_at), 64'd4);
        chk("wr_err",    64'(got_err), 64'd0);
        chk("wr_rdata",  64'(got_rd), 64'habcd);

        // open ring: timeout 16 cycles after the request pulse
        resp_en = 1'b0;
        do_txn(1'b1, 23'h00_0020, 32'h0, 24, -1, -1, -1);
        chk("to_req_at", 64'(req_at), 64'd2);
        chk("to_ack_at", 64'(ack_at), 64'd18);
        chk("to_n_ack",  64'(n_ack), 64'd1);
        chk("to_data",   64'(got_rd), 64'(DEAD));
        chk("to_err",    64'(got_err), 64'd1);
        chk("to_hold",   64'(host_rd_data), 64'(DEAD));

        // return without ack
        resp_en = 1'b1; resp_ack = 1'b0; resp_data = 32'h1111_2222;
        do_txn(1'b1, 23'h00_0030, 32'h0, 10, -1, -1, -1);
        chk("nak_ack_at", 64'(ack_at), 64'd4);
        chk("nak_data",   64'(got_rd), 64'(DEAD));
        chk("nak_err",    64'(got_err), 64'd1);

        // foreign source return during WAIT is ignored, watchdog keeps going
        resp_en = 1'b0; resp_ack = 1'b1;
        inj_src = 2'd1; inj_ack = 1'b1; inj_data = 32'h0000_0077;
        do_txn(1'b1, 23'h00_0040, 32'h0, 24, -1, -1, 6);
        chk("fgn_ack_at", 64'(ack_at), 64'd18);
        chk("fgn_n_ack",  64'(n_ack), 64'd1);
        chk("fgn_err",    64'(got_err), 64'd1);
        chk("fgn_data",   64'(got_rd), 64'(DEAD));

        // return in the expiry cycle wins over the timeout
        inj_src = 2'd0; inj_ack = 1'b1; inj_data = 32'h0000_0099;
        do_txn(1'b1, 23'h00_0050, 32'h0, 24, -1, -1, 17);
        chk("race_ack_at", 64'(ack_at), 64'd18);
        chk("race_err",    64'(got_err), 64'd0);
        chk("race_data",   64'(got_rd), 64'h99);

        // host_req in ISSUE and WAIT is ignored
        resp_en = 1'b1; resp_ack = 1'b1; resp_data = 32'h0000_0042;
        do_txn(1'b1, 23'h00_0060, 32'h0, 12, 1, 3, -1);
        chk("dup_n_req",  64'(n_req), 64'd1);
        chk("dup_n_ack",  64'(n_ack), 64'd1);
        chk("dup_ack_at", 64'(ack_at), 64'd4);
        chk("dup_data",   64'(got_rd), 64'h42);

        // late return after a timeout produces no second ack
        resp_en = 1'b0;
        inj_src = 2'd0; inj_ack = 1'b1; inj_data = 32'h0000_0055;
        do_txn(1'b1, 23'h00_0070, 32'h0, 24, -1, -1, 20);
        chk("late_n_ack", 64'(n_ack), 64'd1);
        chk("late_err",   64'(got_err), 64'd1);
        chk("late_hold",  64'(host_rd_data), 64'(DEAD));

        // reset mid-WAIT
        resp_en = 1'b0;
        host_rd_wr_L = 1'b1; host_addr = 23'h00_0080; host_req = 1'b1;
        tick();
        host_req = 1'b0;
        repeat (4) tick();
        chk("mid_busy", 64'(busy), 64'd1);
        reset = 1'b0;
        #1;
        chk("mr_busy",  64'(busy), 64'd0);
        chk("mr_ack",   64'(host_ack), 64'd0);
        chk("mr_rdata", 64'(host_rd_data), 64'd0);
        chk("mr_err",   64'(host_error), 64'd0);
        chk("mr_src",   64'(reg_src_out), 64'd0);
        acks = 0;
        repeat (3) begin tick(); if (host_ack) acks++; end
        reset = 1'b1;
        repeat (20) begin tick(); if (host_ack) acks++; end
        chk("mr_no_ack", 64'(acks), 64'd0);

        resp_en = 1'b1; resp_ack = 1'b1; resp_data = 32'h0000_5a5a;
        do_txn(1'b1, 23'h00_0090, 32'h0, 10, -1, -1, -1);
        chk("post_ack_at", 64'(ack_at), 64'd4);
        chk("post_data",   64'(got_rd), 64'h5a5a);
        chk("post_err",    64'(got_err), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
